// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte enables for a little-endian access of the given size at byte offset lo.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Force the low address bits to the natural alignment of the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic sgn, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enable, registered read.
// Contents are not initialised by the fabric; INIT_FILE only names an image that a
// memory-preload step may attach.
module dmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  if (INIT_FILE != "") begin : g_image_hook
  end

  // Read-before-write access on enabled cycles; only enabled byte lanes are written.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: multi-cycle access with wait states, stall to the
// hazard unit, byte/half/word lanes and load extension.
// Optional: DMEM_MISALIGN_EXC_EN adds misalign_o and suppresses misaligned accesses;
// without it, low address bits are forced to alignment.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid
`ifdef DMEM_MISALIGN_EXC_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sgn_q;
  logic [1:0]            lo_q;
  logic [DEPTH_LOG2-1:0] widx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  mis_q;
  logic                  rvalid_q;

  logic [1:0]            req_lo;
  logic                  req_mis;
  logic                  ram_en;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  // Effective lane offset and misalignment flag of the incoming request.
  always_comb begin
`ifdef DMEM_MISALIGN_EXC_EN
    req_lo  = req_addr[1:0];
    req_mis = is_misaligned(req_size, req_addr[1:0]);
`else
    req_lo  = align_lo(req_size, req_addr[1:0]);
    req_mis = 1'b0;
`endif
  end

  // Access FSM: capture in IDLE, count wait states, pulse completion in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            lo_q    <= req_lo;
            widx_q  <= req_addr[DEPTH_LOG2+1:2];
            wdata_q <= lane_wdata(req_size, req_wdata);
            be_q    <= byte_en(req_size, req_lo);
            mis_q   <= req_mis;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  logic misalign_q;

  // Misalignment flag rides along with the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == ST_WAIT) && (cnt_q == '0) && mis_q;
  end

  assign misalign_o = misalign_q;
`endif

  // The RAM is touched exactly once, on the last wait edge; a reset on that edge wins.
  always_comb begin
    ram_en = (state_q == ST_WAIT) && (cnt_q == '0) && !rst;
    ram_we = we_q && !mis_q;
  end

  dmem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (be_q),
    .addr_i  (widx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Stall while a request is pending or waiting; released in the response cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: stall_o = req_valid;
      ST_WAIT: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Load data from the registered RAM output; stores and suppressed accesses return zero.
  always_comb begin
    rdata_o = '0;
    if (rvalid_q && !we_q && !mis_q) rdata_o = load_extend(size_q, lo_q, sgn_q, ram_rdata);
  end

  assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a transaction-level byte model.
module tb_dmem_responder;

  localparam int DL    = 10;
  localparam int LAT   = 2;
  localparam int BYTES = 4 << DL;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, rdata_valid;
  logic [31:0] rdata_o;
`ifdef DMEM_MISALIGN_EXC_EN
  logic        misalign_o;
  logic        last_mis;
`endif

  dmem_responder #(
    .DEPTH_LOG2 (DL),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .rdata_valid (rdata_valid)
`ifdef DMEM_MISALIGN_EXC_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int completions = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0011_2233;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [BYTES];
  bit          kn [BYTES];
  int          phase = -1;        // -1 idle, 1..LAT waiting, LAT+1 responding
  bit          rst_seen = 0;
  bit          t_we, t_sg;
  logic [1:0]  t_sz;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] exp_rd;
  bit          exp_known, exp_mis;

  task automatic commit();
    int unsigned base, n;
    bit mis;
    logic [31:0] v;
    base = t_addr % BYTES;
    n = (t_sz == 2'b00) ? 1 : (t_sz == 2'b01) ? 2 : 4;
    mis = (base % n) != 0;
`ifdef DMEM_MISALIGN_EXC_EN
    exp_mis = mis;
`else
    exp_mis = 0;
    mis = 0;
`endif
    base = base - (base % n);
    exp_known = 1;
    exp_rd = '0;
    if (mis) begin
      exp_rd = '0;
    end else if (t_we) begin
      for (int k = 0; k < int'(n); k++) begin
        mm[base+k] = t_wdata[8*k +: 8];
        kn[base+k] = 1;
      end
    end else begin
      v = '0;
      for (int k = 0; k < int'(n); k++) begin
        v = v | (32'(mm[base+k]) << (8*k));
        if (!kn[base+k]) exp_known = 0;
      end
      if (n < 4 && t_sg && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rd = v;
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    bit e_valid, e_stall;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        e_valid = (phase == LAT + 1);
        e_stall = (phase < 0) ? req_valid : (phase <= LAT);
        chk("stall_o", 32'(stall_o), 32'(e_stall));
        chk("rdata_valid", 32'(rdata_valid), 32'(e_valid));
        if (!e_valid || exp_known) chk("rdata_o", rdata_o, e_valid ? exp_rd : 32'h0);
`ifdef DMEM_MISALIGN_EXC_EN
        chk("misalign_o", 32'(misalign_o), 32'(e_valid && exp_mis));
`endif
        if (rdata_valid) completions++;
      end
      @(posedge clk);
      if (rst) begin
        phase = -1;
        rst_seen = 1;
      end else if (phase < 0) begin
        if (req_valid) begin
          t_we = req_we; t_sz = req_size; t_sg = req_signed;
          t_addr = req_addr; t_wdata = req_wdata;
          phase = 1;
        end
      end else if (phase == LAT) begin
        commit();
        phase = LAT + 1;
      end else if (phase == LAT + 1) begin
        phase = -1;
      end else begin
        phase++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present a request (called 1 time unit after a rising edge) and hold it until completion.
  task automatic txn(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output int stalls,
                     output int lat);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    stalls = 0; lat = 0;
    #1;
    if (stall_o) stalls++;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (rdata_valid) break;
      if (stall_o) stalls++;
      if (lat > 50) begin
        chk("completion timeout", 32'(lat), 32'(LAT + 1));
        break;
      end
    end
    rd = rdata_o;
`ifdef DMEM_MISALIGN_EXC_EN
    last_mis = misalign_o;
`endif
  endtask

  initial begin
    logic [31:0] rd, w20;
    int st, lt, c0;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall_o", 32'(stall_o), 32'h0);
    chk("reset rdata_valid", 32'(rdata_valid), 32'h0);
    chk("reset rdata_o", rdata_o, 32'h0);
    rst = 1'b0;

    // Known contents for the first 32 words.
    for (int i = 0; i < 32; i++) txn(1, 2'b10, 0, 32'(4*i), init_val(i), rd, st, lt);

    // Word store/load with latency and stall length.
    idle(1);
    txn(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, rd, st, lt);
    chk("st_word stall", 32'(st), 32'd3);
    chk("st_word latency", 32'(lt), 32'd3);
    chk("st_word rdata", rd, 32'h0);
    idle(1);
    txn(0, 2'b10, 0, 32'h10, 32'h0, rd, st, lt);
    chk("ld_word stall", 32'(st), 32'd3);
    chk("ld_word latency", 32'(lt), 32'd3);
    chk("ld_word data", rd, 32'hDEAD_BEEF);
    idle(1);
    txn(0, 2'b10, 0, 32'hFFFF_F010, 32'h0, rd, st, lt);
    chk("ld_word wrap", rd, 32'hDEAD_BEEF);

    // Byte lane store and extension.
    idle(1);
    txn(1, 2'b00, 0, 32'h21, 32'h7777_7780, rd, st, lt);
    txn(0, 2'b00, 1, 32'h21, 32'h0, rd, st, lt);
    chk("ld_byte signed", rd, 32'hFFFF_FF80);
    txn(0, 2'b00, 0, 32'h21, 32'h0, rd, st, lt);
    chk("ld_byte unsigned", rd, 32'h0000_0080);
    txn(0, 2'b10, 0, 32'h20, 32'h0, rd, st, lt);
    chk("byte neighbours", rd, (init_val(8) & 32'hFFFF_00FF) | 32'h0000_8000);

    // Half lane store.
    txn(1, 2'b01, 0, 32'h32, 32'hABCD_1234, rd, st, lt);
    txn(0, 2'b01, 0, 32'h32, 32'h0, rd, st, lt);
    chk("ld_half unsigned", rd, 32'h0000_1234);
    txn(0, 2'b10, 0, 32'h30, 32'h0, rd, st, lt);
    chk("half upper lane", rd >> 16, 32'h0000_1234);
    chk("half lower lane", rd & 32'hFFFF, init_val(12) & 32'hFFFF);

    // Back-to-back loads with req_valid held through the response cycle.
    idle(1);
    c0 = completions;
    txn(0, 2'b10, 0, 32'h10, 32'h0, rd, st, lt);
    txn(0, 2'b10, 0, 32'h24, 32'h0, rd, st, lt);
    chk("b2b second latency", 32'(lt), 32'(LAT + 2));
    chk("b2b second data", rd, init_val(9));
    idle(3);
    chk("b2b completions", 32'(completions - c0), 32'd2);

    // Reset during the wait phase of a store abandons it.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h50; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst abort stall_o", 32'(stall_o), 32'h0);
    chk("rst abort rdata_valid", 32'(rdata_valid), 32'h0);
    idle(1);
    txn(0, 2'b10, 0, 32'h50, 32'h0, rd, st, lt);
    w20 = init_val(20);
    chk("rst abort old data", rd, w20);

    // Misaligned word store.
    idle(1);
    txn(1, 2'b10, 0, 32'h42, 32'h55AA_55AA, rd, st, lt);
`ifdef DMEM_MISALIGN_EXC_EN
    chk("misalign flag", 32'(last_mis), 32'h1);
    txn(0, 2'b10, 0, 32'h40, 32'h0, rd, st, lt);
    chk("misalign no write", rd, init_val(16));
`else
    txn(0, 2'b10, 0, 32'h40, 32'h0, rd, st, lt);
    chk("aligned word write", rd, 32'h55AA_55AA);
`endif

    // Random traffic inside the initialised window, some with aliased upper bits.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int gap;
      gap = int'($urandom_range(0, 2));
      if (gap != 0) idle(gap);
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      txn(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
          a, $urandom, rd, st, lt);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
